// File: rtl/pipe_mult_pkg.sv
// pipe_mult_pkg: shared types and sizing helpers for the parametrised pipelined multiplier.
package pipe_mult_pkg;

    typedef enum logic {MUL_UNSIGNED, MUL_SIGNED} mul_mode_e;

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    function automatic int tree_depth(input int terms);
        return $clog2(terms);
    endfunction

    // Number of live terms after lvl rounds of pairwise addition.
    function automatic int level_count(input int terms, input int lvl);
        return (terms + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/pipe_mult_pp_gen.sv
// pipe_mult_pp_gen: combinational partial products of one operand pair, MSB term negated in signed mode.
module pipe_mult_pp_gen
    import pipe_mult_pkg::*;
#(
    parameter int A_W = 8,
    parameter int B_W = 8,
    localparam int P_W = prod_width(A_W, B_W)
) (
    input  logic [A_W-1:0]            a,
    input  logic [B_W-1:0]            b,
    input  mul_mode_e                 mode,
    output logic [B_W-1:0][P_W-1:0]   pp
);

    logic [P_W-1:0] ext;

    assign ext = {{B_W{mode == MUL_SIGNED && a[A_W-1]}}, a};

    always_comb begin
        for (int i = 0; i < B_W; i++)
            pp[i] = !b[i] ? '0
                  : (mode == MUL_SIGNED && i == B_W - 1) ? P_W'(~(ext << i) + 1'b1)
                  : ext << i;
    end

endmodule

// File: rtl/pipe_mult_gen.sv
// pipe_mult_gen: A_W x B_W signed/unsigned multiplier with a registered partial-product stage,
// a registered binary adder tree and a globally stalled valid/ready pipeline.
module pipe_mult_gen
    import pipe_mult_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int TAG_W = 4,
    localparam int P_W   = prod_width(A_W, B_W),
    localparam int DEPTH = tree_depth(B_W),
    localparam int LAT   = 1 + DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_W-1:0]   out_product,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N0 = 1 << DEPTH;

    logic                          adv;
    logic [B_W-1:0]                b_in;
    logic [TAG_W-1:0]              tag_in;
    logic [B_W-1:0][P_W-1:0]       pp;
    logic [N0-1:0][P_W-1:0]        pp_pad;
    // Heap-ordered tree: node k sums nodes 2k+1 and 2k+2, leaves start at N0-1, root is node 0.
    logic [2*N0-2:0][P_W-1:0]      heap;
    logic [LAT-1:0]                vld;
    logic [LAT-1:0][TAG_W-1:0]     tag;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    // Bubbles carry all-zero data so idle stages never hold stale products.
    assign b_in     = in_valid ? in_b : '0;
    assign tag_in   = in_valid ? in_tag : '0;
    assign pp_pad   = (N0 * P_W)'(pp);

    pipe_mult_pp_gen #(.A_W(A_W), .B_W(B_W)) u_pp (
        .a    (in_a),
        .b    (b_in),
        .mode (mul_mode_e'(in_signed)),
        .pp   (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            heap <= '0;
            vld  <= '0;
            tag  <= '0;
        end else if (adv) begin
            for (int i = 0; i < N0; i++)
                heap[N0-1+i] <= pp_pad[i];
            for (int k = 0; k < N0 - 1; k++)
                heap[k] <= heap[2*k+1] + heap[2*k+2];
            vld <= {vld[LAT-2:0], in_valid};
            tag <= {tag[LAT-2:0], tag_in};
        end
    end

    assign out_valid   = vld[LAT-1];
    assign out_tag     = tag[LAT-1];
    assign out_product = heap[0];

endmodule

// File: tb/tb_pipe_mult_gen.sv
// tb_pipe_mult_gen: directed and random checks of pipe_mult_gen at 8x8, 5x3 and 16x16
// against an arithmetic product model with in-order scoreboards.
module tb_pipe_mult_gen;

    typedef struct {
        logic [63:0] prod;
        logic [63:0] tag;
        int          acc_e;
        int          acc_s;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    int   errors = 0;
    int   checks = 0;
    int   ecount = 0;

    logic [2:0] rand_en = '0;
    logic       d_valid = 0, d_signed = 0, d_ordy = 1;
    logic [7:0] d_a = 0, d_b = 0;
    logic [3:0] d_tag = 0;

    logic        dv_ready, dv_ovalid;
    logic [15:0] dv_prod;
    logic [3:0]  dv_otag;
    int          delivered [3];
    logic        fin [3];

    logic [7:0]  ia   [6] = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'hFF, 8'hFF};
    logic [7:0]  ib   [6] = '{8'hFF, 8'hFF, 8'h02, 8'h02, 8'hFF, 8'hFF};
    logic        isg  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] iexp [6] = '{16'hFE01, 16'h0001, 16'h0100, 16'hFF00, 16'hFE01, 16'h0001};

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    function automatic logic [63:0] model(input int pw, input int aw, input int bw,
                                          input logic sgn, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[aw-1]) sa = sa - (longint'(1) << aw);
        if (sgn && b[bw-1]) sb = sb - (longint'(1) << bw);
        p = sa * sb;
        return 64'(p) & ((64'd1 << pw) - 64'd1);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int AW   = (g == 0) ? 8 : (g == 1) ? 5 : 16;
        localparam int BW   = (g == 0) ? 8 : (g == 1) ? 3 : 16;
        localparam int PW   = AW + BW;
        localparam int LATC = 1 + $clog2(BW);

        logic          in_valid, in_ready, in_signed, out_valid, out_ready;
        logic [AW-1:0] in_a;
        logic [BW-1:0] in_b;
        logic [3:0]    in_tag, out_tag;
        logic [PW-1:0] out_product;

        logic          r_valid = 0, r_signed = 0, r_ordy = 1;
        logic [AW-1:0] r_a = '0;
        logic [BW-1:0] r_b = '0;
        logic [3:0]    r_tag = '0;
        logic          fire = 0, prev_stall = 0;
        logic [PW-1:0] held_p = '0;
        logic [3:0]    held_t = '0;
        int            stalls = 0, n_u = 0, n_s = 0;
        exp_t          q[$];
        exp_t          e;

        assign in_valid  = rand_en[g] ? r_valid  : d_valid;
        assign in_signed = rand_en[g] ? r_signed : d_signed;
        assign in_a      = rand_en[g] ? r_a      : AW'(d_a);
        assign in_b      = rand_en[g] ? r_b      : BW'(d_b);
        assign in_tag    = rand_en[g] ? r_tag    : d_tag;
        assign out_ready = rand_en[g] ? r_ordy   : d_ordy;

        pipe_mult_gen #(.A_W(AW), .B_W(BW), .TAG_W(4)) dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid),
            .in_ready    (in_ready),
            .in_a        (in_a),
            .in_b        (in_b),
            .in_signed   (in_signed),
            .in_tag      (in_tag),
            .out_valid   (out_valid),
            .out_ready   (out_ready),
            .out_product (out_product),
            .out_tag     (out_tag)
        );

        if (g == 0) begin : tap
            assign dv_ready  = in_ready;
            assign dv_ovalid = out_valid;
            assign dv_prod   = out_product;
            assign dv_otag   = out_tag;
        end

        initial begin
            forever begin
                @(posedge clk);
                #1;
                if (rand_en[g] && (!r_valid || fire)) begin
                    if (n_u < 2000 || n_s < 2000) begin
                        r_valid  = $urandom_range(0, 3) != 0;
                        r_a      = AW'($urandom);
                        r_b      = BW'($urandom);
                        r_tag    = 4'($urandom);
                        r_signed = (n_s >= 2000) ? 1'b0 : (n_u >= 2000) ? 1'b1 : 1'($urandom_range(0, 1));
                        if (r_valid && r_signed) n_s++;
                        else if (r_valid) n_u++;
                    end else begin
                        r_valid = 0;
                    end
                end
                if (rand_en[g]) r_ordy = $urandom_range(0, 3) != 0;
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                prev_stall = 0;
                fire = 0;
            end else begin
                check($sformatf("cfg%0d in_ready", g), 64'(in_ready), 64'(!out_valid || out_ready));
                if (out_valid && prev_stall) begin
                    check($sformatf("cfg%0d held product", g), 64'(out_product), 64'(held_p));
                    check($sformatf("cfg%0d held tag", g), 64'(out_tag), 64'(held_t));
                end else if (out_valid) begin
                    if (q.size() == 0) begin
                        check($sformatf("cfg%0d spurious out_valid", g), 64'(out_valid), 64'd0);
                    end else begin
                        e = q[0];
                        check($sformatf("cfg%0d product", g), 64'(out_product), e.prod);
                        check($sformatf("cfg%0d tag", g), 64'(out_tag), e.tag);
                        check($sformatf("cfg%0d latency", g), 64'(ecount), 64'(e.acc_e + LATC + stalls - e.acc_s));
                    end
                end else if (prev_stall) begin
                    check($sformatf("cfg%0d valid held in stall", g), 64'(out_valid), 64'd1);
                end
                prev_stall = out_valid && !out_ready;
                if (prev_stall) stalls++;
                held_p = out_product;
                held_t = out_tag;
                if (out_valid && out_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    delivered[g]++;
                end
                fire = in_valid && in_ready;
                if (fire)
                    q.push_back('{model(PW, AW, BW, in_signed, 64'(in_a), 64'(in_b)), 64'(in_tag), ecount, stalls});
            end
            fin[g] = n_u >= 2000 && n_s >= 2000 && !r_valid && q.size() == 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [3:0] t, input logic [15:0] exp, input string nm);
        d_a = a; d_b = b; d_signed = s; d_tag = t; d_valid = 1; d_ordy = 1;
        #1;
        check({nm, " in_ready"}, 64'(dv_ready), 64'd1);
        step();
        d_valid = 0;
        repeat (2) step();
        check({nm, " not yet valid"}, 64'(dv_ovalid), 64'd0);
        step();
        check({nm, " valid"}, 64'(dv_ovalid), 64'd1);
        check({nm, " product"}, 64'(dv_prod), 64'(exp));
        check({nm, " tag"}, 64'(dv_otag), 64'(t));
    endtask

    initial begin
        int base, sent;
        logic acc;
        logic [15:0] held;

        check("model u 255*255", model(16, 8, 8, 0, 64'hFF, 64'hFF), 64'hFE01);
        check("model s -128*-128", model(16, 8, 8, 1, 64'h80, 64'h80), 64'h4000);
        check("model s 127*-128", model(16, 8, 8, 1, 64'h7F, 64'h80), 64'hC080);
        check("model 5x3 s -16*-4", model(8, 5, 3, 1, 64'h10, 64'h4), 64'h40);
        check("model 16x16 s -1*2", model(32, 16, 16, 1, 64'hFFFF, 64'h2), 64'hFFFF_FFFE);

        repeat (3) step();
        rst = 0;
        check("reset out_valid", 64'(dv_ovalid), 64'd0);
        check("reset out_product", 64'(dv_prod), 64'd0);
        check("reset out_tag", 64'(dv_otag), 64'd0);
        check("reset in_ready", 64'(dv_ready), 64'd1);

        one(8'hFF, 8'hFF, 0, 4'h5, 16'hFE01, "u 255*255");
        one(8'h00, 8'd200, 0, 4'hA, 16'h0000, "u 0*200");
        one(8'h80, 8'h80, 1, 4'h3, 16'h4000, "s -128*-128");
        one(8'hFF, 8'h01, 1, 4'h7, 16'hFFFF, "s -1*1");
        one(8'h7F, 8'h80, 1, 4'hC, 16'hC080, "s 127*-128");
        step();

        for (int k = 0; k < 9; k++) begin
            d_valid = k < 6;
            if (k < 6) begin
                d_a = ia[k]; d_b = ib[k]; d_signed = isg[k]; d_tag = 4'(k);
            end
            step();
            if (k >= 3) begin
                check($sformatf("interleave %0d valid", k - 3), 64'(dv_ovalid), 64'd1);
                check($sformatf("interleave %0d product", k - 3), 64'(dv_prod), 64'(iexp[k-3]));
            end
        end
        d_valid = 0;
        step();

        base = delivered[0];
        sent = 0;
        held = '0;
        for (int c = 0; c < 60 && sent < 10; c++) begin
            d_ordy = !(c inside {[6:8]});
            d_valid = 1;
            d_a = 8'($urandom); d_b = 8'($urandom); d_signed = 1'($urandom); d_tag = 4'(sent);
            #1;
            acc = dv_ready;
            if (c inside {[6:8]}) begin
                check("stall in_ready", 64'(dv_ready), 64'd0);
                if (c == 6) held = dv_prod;
                else check("stall product stable", 64'(dv_prod), 64'(held));
            end
            step();
            if (acc) sent++;
        end
        d_valid = 0;
        d_ordy = 1;
        for (int c = 0; c < 30 && delivered[0] - base < 10; c++) step();
        check("backpressure delivered", 64'(delivered[0] - base), 64'd10);
        step();

        for (int k = 0; k < 16; k++) begin
            d_valid = (k < 12) && (k % 2 == 0);
            d_a = 8'(k + 1); d_b = 8'd3; d_signed = 0; d_tag = 4'(k);
            step();
            if (k >= 3) check($sformatf("bubble pattern %0d", k), 64'(dv_ovalid), 64'((k - 3) < 12 && (k - 3) % 2 == 0));
        end
        d_valid = 0;

        for (int k = 0; k < 3; k++) begin
            d_valid = 1; d_a = 8'h11 + 8'(k); d_b = 8'h22; d_signed = 0; d_tag = 4'(k);
            step();
        end
        rst = 1;
        d_a = 8'h55; d_b = 8'h66;
        step();
        rst = 0;
        d_valid = 0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("post-reset %0d out_valid", k), 64'(dv_ovalid), 64'd0);
            check($sformatf("post-reset %0d out_product", k), 64'(dv_prod), 64'd0);
            if (k < 4) step();
        end
        one(8'd3, 8'd5, 0, 4'h9, 16'h000F, "after reset 3*5");
        step();

        rand_en = 3'b111;
        for (int c = 0; c < 60000 && !(fin[0] && fin[1] && fin[2]); c++) step();
        for (int g = 0; g < 3; g++) check($sformatf("cfg%0d random drained", g), 64'(fin[g]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_mult_gen.md
# pipe_mult_gen

Parametrised successor to the fixed 8x8 pipelined multiplier in the systolic-array PE datapath. It multiplies an A_W-bit operand by a B_W-bit operand, in signed or unsigned mode selected per transaction, and returns the full-width product. It uses a registered partial-product stage and a registered binary adder tree. It adds valid/ready backpressure and a sideband tag so PEs and drain logic can stall it without losing in-flight data.

## Interface
- A_W, default 8: operand A width, ≥2.
- B_W, default 8: operand B width, ≥2; sets the partial-product count.
- TAG_W, default 4: sideband tag width, ≥1; the tag travels with its operands.
- P_W (localparam): A_W+B_W, product width.
- DEPTH (localparam): $clog2(B_W), adder-tree levels.
- LAT (localparam): 1+DEPTH, pipeline latency in cycles; 4 at defaults.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  A_W  multiplicand.
- in_b  in  B_W  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_tag  in  TAG_W  opaque sideband.
- out_valid  out  1  product beat present.
- out_ready  in  1  consumer accepts.
- out_product  out  P_W  full product, never truncated.
- out_tag  out  TAG_W  tag of the same beat.

## Operation
- Global enable: adv = !out_valid || out_ready. All stage registers and valid bits update only when adv=1, otherwise they hold.
- in_ready = adv, combinational.
- Accept: a beat is accepted when in_valid && in_ready. When adv=1 and in_valid=0, a bubble (valid=0) enters.
- Stage 0, partial products: LAT stage 0 registers B_W partial products, each P_W wide.
  - Unsigned: pp[i] = b[i] ? zero-extended a << i : 0.
  - Signed: pp[i] = b[i] ? sign-extended a << i : 0 for i<B_W-1. pp[B_W-1] is the two's-complement negation of that term (MSB weight is negative).
  - The mode bit is consumed in stage 0 only.
- Adder tree, stages 1..DEPTH:
  - Each level sums adjacent pairs modulo 2^P_W.
  - An odd leftover is passed through registered.
  - Non-power-of-2 B_W pads with zero terms.
- Tag and valid: they shift alongside the data with the same enable, forming a LAT-deep shift register.
- Outputs: out_product, out_tag and out_valid come directly from the final-stage registers.
- Reset (synchronous): every valid bit, data register and tag register is cleared to 0. After reset, out_valid=0, out_product=0, out_tag=0, in_ready=1.
- Reset mid-operation discards all in-flight beats with no partial output. The beat presented in the reset cycle is not accepted.

## Timing
- Latency: a beat accepted at edge N appears on out_valid at edge N+LAT, provided no stall intervenes. Each stall cycle adds exactly one cycle.
- Throughput: one beat per cycle while out_ready=1.
- Holding: out_valid=1 with out_ready=0 freezes the entire pipe, including bubbles; no bubble compaction. out_product and out_tag stay stable until the handshake.
- Full pipe plus stall: in_ready=0 and the source must hold its beat.
- Simultaneous out handshake and new input: both occur in the same cycle.
- out_ready is ignored when out_valid=0.

## Structure
- Package pipe_mult_pkg:
  - typedef enum logic {MUL_UNSIGNED, MUL_SIGNED} mul_mode_e
  - localparam function for tree depth and per-level width counts
  - shared P_W helper
- Sub-module pipe_mult_pp_gen: combinational partial-product generation for one operand pair, parametrised on A_W and B_W, including signed negation of the MSB term.
- Top level: stage registers, generate-loop adder tree, valid/tag shift chain and the adv/in_ready logic.

## Test plan
- Unsigned, defaults: a=255, b=255 -> out_product=0xFE01 exactly 4 cycles later, tag preserved. a=0, b=200 -> 0x0000.
- Signed, defaults:
  - -128*-128 -> 0x4000
  - -1*1 -> 0xFFFF
  - 127*-128 -> 0xC080
  - Interleave with unsigned beats, one per cycle, and check mode isolation per beat.
- Backpressure: stream 10 tagged beats and hold out_ready=0 for 3 cycles mid-stream. Required:
  - in_ready=0 while stalled
  - out_product/out_tag stable while stalled
  - all 10 beats delivered in order, none dropped or duplicated
- Bubbles: toggle in_valid every other cycle with out_ready=1 -> out_valid shows the same pattern shifted by 4 cycles.
- Reset mid-operation: assert rst for one cycle with 3 beats in flight -> out_valid stays 0 for the next 4 cycles, out_product=0, and the next accepted beat emerges with latency 4.
- Parameter sweep: A_W=5/B_W=3 (LAT=3) and A_W=16/B_W=16 (LAT=5). Random 2000 beats per mode against a reference model, with random out_ready; all products must match bit-exact.
